// File: rtl/dither_stream_tx.sv
// Readout engine: streams the dithered pixel SRAM to the MCU as 1-bit pixels packed MSB-first.
// Define DITHER_TX_RAW_EN to bypass packing and stream each raw SRAM byte instead.
module dither_stream_tx #(
  parameter int IMAGEX           = 64,
  parameter int IMAGEY           = 64,
  parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
  parameter int RGB_SIZE         = 8,
  parameter int PACK_BITS        = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        sram_rden,
  output logic [15:0]                 sram_address,
  input  logic [RGB_SIZE-1:0]         sram_q,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic                        done,
  output logic [IMAGE_ADDR_WIDTH-1:0] byte_count,
  output logic [2:0]                  state_dbg
);

  // Handshake: a byte moves when tx_valid && tx_ready at posedge clk; while tx_valid is
  // high and tx_ready low, tx_valid and tx_data hold.

  // idx must be able to hold IMAGE_SIZE itself, hence one extra bit.
  localparam int IW = IMAGE_ADDR_WIDTH + 1;
  localparam logic [IW-1:0] SIZE_W = IW'(IMAGE_SIZE);
  localparam logic [3:0]    PACK_W = 4'(PACK_BITS);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, STALL, FLUSH, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_inc;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    shift_nxt;
  logic [7:0]    flush_byte;
  logic          byte_done;
  logic          flush_pending;
  logic          can_issue;

  logic [7:0]    fifo_mem [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    fifo_cnt;
  logic          push, pop;
  logic [7:0]    push_data;
  logic          sram_q_unused;

  assign sram_q_unused = ^sram_q;
  assign idx_inc       = idx + 1'b1;
  assign shift_nxt     = {shift[6:0], sram_q[RGB_SIZE-1]};
  assign flush_byte    = shift << (PACK_W - {1'b0, bit_cnt});

`ifdef DITHER_TX_RAW_EN
  assign byte_done     = 1'b1;
  assign flush_pending = 1'b0;
`else
  assign byte_done     = (bit_cnt == 3'd7);
  assign flush_pending = (bit_cnt != 3'd0);
`endif

  // A pixel that completes a byte may only be fetched if the FIFO has room for it.
  assign can_issue = (fifo_cnt != 2'd2) || !byte_done;

  assign tx_valid  = (fifo_cnt != 2'd0);
  assign tx_data   = fifo_mem[rd_ptr];
  assign pop       = tx_valid && tx_ready;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_comb begin
    state_nxt    = state;
    push         = 1'b0;
    push_data    = shift_nxt;
    sram_rden    = 1'b0;
    sram_address = '0;
    case (state)
      IDLE: if (start) state_nxt = FETCH;
      FETCH: begin
        if (can_issue) begin
          sram_rden    = 1'b1;
          sram_address = 16'(idx);
          state_nxt    = CAPTURE;
        end else begin
          state_nxt = STALL;
        end
      end
      CAPTURE: begin
        push = byte_done;
`ifdef DITHER_TX_RAW_EN
        push_data = 8'(sram_q);
`endif
        state_nxt = (idx_inc < SIZE_W) ? FETCH : FLUSH;
      end
      STALL: if (fifo_cnt != 2'd2) state_nxt = FETCH;
      FLUSH: begin
        if (!flush_pending) begin
          state_nxt = DRAIN;
        end else if (fifo_cnt != 2'd2) begin
          push      = 1'b1;
          push_data = flush_byte;
          state_nxt = DRAIN;
        end
      end
      DRAIN: if (fifo_cnt == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_count <= '0;
      done       <= 1'b0;
    end else begin
      // done rises on the same edge that returns the FSM to IDLE, so busy falls with it.
      done <= (state == DRAIN) && (fifo_cnt == 2'd0);
      if (state == IDLE && start) begin
        idx        <= '0;
        bit_cnt    <= '0;
        shift      <= '0;
        byte_count <= '0;
      end else begin
        if (pop) byte_count <= byte_count + 1'b1;
        if (state == CAPTURE) begin
          idx     <= idx_inc;
          shift   <= shift_nxt;
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dither_stream_tx.sv
// Bench for dither_stream_tx: randomized SRAM images and tx_ready patterns scored against
// a frame-level packing model; a second 3x3 instance covers the padded tail byte.
module tb_dither_stream_tx;

  localparam int N  = 4096;
  localparam int AW = 12;
`ifdef DITHER_TX_RAW_EN
  localparam bit RAW = 1'b1;
`else
  localparam bit RAW = 1'b0;
`endif
  localparam int TOTAL = RAW ? N : (N + 7) / 8;
  localparam int LAT   = RAW ? 3 : 17;

  logic          clk, rst, start;
  logic          sram_rden;
  logic [15:0]   sram_address;
  logic [7:0]    sram_q;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_ready, busy, done;
  logic [AW-1:0] byte_count;
  logic [2:0]    state_dbg;

  logic          s_start, s_rden, s_valid, s_busy, s_done;
  logic          s_ready;
  logic [15:0]   s_addr;
  logic [7:0]    s_q, s_data;
  logic [3:0]    s_bc;
  logic [2:0]    s_state;

  logic [7:0]    mem_a [N];
  logic [7:0]    s_mem [9];
  logic [7:0]    pix_q [$];
  logic [7:0]    exp_q [$];

  int            n_checks, n_fail;
  int            exp_addr, acc_cnt, done_cnt;
  bit            ready_en, rand_ready, mon_en;
  logic          prev_stall;
  logic [7:0]    prev_data;

  dither_stream_tx u_dut (
    .clk(clk), .rst(rst), .start(start), .sram_rden(sram_rden), .sram_address(sram_address),
    .sram_q(sram_q), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .byte_count(byte_count), .state_dbg(state_dbg)
  );

  dither_stream_tx #(.IMAGEX(3), .IMAGEY(3)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .sram_rden(s_rden), .sram_address(s_addr),
    .sram_q(s_q), .tx_data(s_data), .tx_valid(s_valid), .tx_ready(s_ready),
    .busy(s_busy), .done(s_done), .byte_count(s_bc), .state_dbg(s_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read SRAM models: data the cycle after rden
  always @(posedge clk) if (sram_rden) sram_q <= mem_a[sram_address[AW-1:0]];
  always @(posedge clk) if (s_rden) s_q <= (s_addr < 16'd9) ? s_mem[s_addr[3:0]] : 8'hxx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame model: threshold at 128, 8 pixels per byte MSB-first, zero-padded tail.
  function automatic void build_exp();
    exp_q.delete();
    if (RAW) begin
      foreach (pix_q[i]) exp_q.push_back(pix_q[i]);
    end else begin
      for (int b = 0; b < (pix_q.size() + 7) / 8; b++) begin
        logic [7:0] v;
        v = 8'h00;
        for (int j = 0; j < 8; j++)
          if (b * 8 + j < pix_q.size() && pix_q[b * 8 + j] >= 8'd128) v = v | (8'h80 >> j);
        exp_q.push_back(v);
      end
    end
  endfunction

  task automatic load_image(input int pattern);
    pix_q.delete();
    for (int i = 0; i < N; i++) begin
      case (pattern)
        0:       mem_a[i] = 8'hFF;
        1:       mem_a[i] = (i % 2 == 0) ? 8'h80 : 8'h7F;
        2:       mem_a[i] = 8'(i % 256);
        default: mem_a[i] = 8'($urandom_range(0, 255));
      endcase
      pix_q.push_back(mem_a[i]);
    end
    build_exp();
    exp_addr = 0;
    acc_cnt  = 0;
    done_cnt = 0;
  endtask

  // tx_ready driver + scoreboard/monitor
  initial begin
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      tx_ready = ready_en && (!rand_ready || ($urandom_range(0, 3) != 0));
      #1;
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", tx_valid, 1);
          check("hold_data", tx_data, prev_data);
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (sram_rden) begin
          check("rd_addr", sram_address, exp_addr);
          exp_addr++;
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) check("extra_byte", 1, 0);
          else check("byte", tx_data, exp_q.pop_front());
          acc_cnt++;
        end
        if (done) begin
          done_cnt++;
          check("done_bytes", acc_cnt, TOTAL);
          check("done_byte_count", byte_count, TOTAL % (1 << AW));
          check("done_busy", busy, 0);
        end
      end
    end
  end

  task automatic run_frame(input bit rnd, input bit extra_starts, input bit hold);
    bit first, holding;
    int hold_left;
    first      = 1'b0;
    holding    = 1'b0;
    hold_left  = 0;
    rand_ready = rnd;
    ready_en   = !hold;
    mon_en     = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int c = 1; c < 40000 && done_cnt == 0; c++) begin
      @(negedge clk);
      if (!first && tx_valid) begin
        first = 1'b1;
        check("first_byte_latency", c + 1, LAT);
        if (hold) begin
          holding   = 1'b1;
          hold_left = 40;
        end
      end else if (holding) begin
        hold_left--;
        if (hold_left < 5) check("stall_rden", sram_rden, 0);
        if (hold_left == 0) begin
          holding  = 1'b0;
          ready_en = 1'b1;
        end
      end
      start = (extra_starts && acc_cnt + 4 < TOTAL && $urandom_range(0, 40) == 0);
    end
    start = 1'b0;
    check("frame_done", done_cnt, 1);
    check("frame_bytes", acc_cnt, TOTAL);
    check("frame_leftover", exp_q.size(), 0);
    check("frame_reads", exp_addr, N);
    repeat (4) @(negedge clk);
    check("done_single", done_cnt, 1);
    check("idle_busy", busy, 0);
    check("idle_state", state_dbg, 0);
    check("idle_byte_count", byte_count, TOTAL % (1 << AW));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rden"}, sram_rden, 0);
    check({tag, "_addr"}, sram_address, 0);
    check({tag, "_data"}, tx_data, 0);
    check({tag, "_valid"}, tx_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_byte_count"}, byte_count, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    int max_addr;
    bit s_seen_done;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    s_start  = 1'b0;
    s_ready  = 1'b1;
    ready_en = 1'b1;
    rand_ready = 1'b0;
    mon_en   = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_small_valid", s_valid, 0);
    rst = 1'b1;
    @(negedge clk);

    load_image(0); run_frame(0, 0, 0);
    load_image(1); run_frame(0, 0, 0);
    load_image(2); run_frame(0, 0, 0);
    load_image(3); run_frame(0, 0, 1);
    load_image(3); run_frame(1, 1, 0);

    // abort mid-frame with reset, then a fresh full frame
    load_image(3);
    rand_ready = 1'b1;
    ready_en   = 1'b1;
    mon_en     = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 20000 && acc_cnt <= 100; c++) @(negedge clk);
    check("abort_reached_100", acc_cnt > 100, 1);
    #2 rst = 1'b0;
    #1 mon_en = 1'b0;
    check_all_zero("abort");
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    check("abort_done_count", done_cnt, 0);
    rst = 1'b1;
    @(negedge clk);
    load_image(3); run_frame(1, 1, 0);
    mon_en = 1'b0;

    // 3x3 instance: padded tail byte / raw bytes and address bound
    pix_q.delete();
    for (int i = 0; i < 9; i++) begin
      s_mem[i] = RAW ? 8'(i + 1) : 8'hFF;
      pix_q.push_back(s_mem[i]);
    end
    build_exp();
    check("small_expected_len", exp_q.size(), RAW ? 9 : 2);
    max_addr    = 0;
    s_seen_done = 1'b0;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    for (int c = 0; c < 500 && !s_seen_done; c++) begin
      @(negedge clk);
      if (s_rden && int'(s_addr) > max_addr) max_addr = int'(s_addr);
      if (s_valid) begin
        if (exp_q.size() == 0) check("small_extra_byte", 1, 0);
        else check("small_byte", s_data, exp_q.pop_front());
      end
      if (s_done) begin
        s_seen_done = 1'b1;
        check("small_byte_count", s_bc, RAW ? 9 : 2);
        check("small_busy", s_busy, 0);
      end
    end
    check("small_done", s_seen_done, 1);
    check("small_leftover", exp_q.size(), 0);
    check("small_max_addr", max_addr, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
